// File: rtl/bitblade_pkg.sv
// Shared opcode, FSM-state and width definitions for the BitBlade CFU front-end.
package bitblade_pkg;

    localparam int DOT_W = 18;

    localparam logic [2:0] OP_MAC   = 3'd0;
    localparam logic [2:0] OP_DOT   = 3'd1;
    localparam logic [2:0] OP_CLR   = 3'd2;
    localparam logic [2:0] OP_RD    = 3'd3;
    localparam logic [2:0] OP_LD    = 3'd4;
    localparam logic [2:0] OP_SATRD = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bitblade_dot4.sv
// Purely combinational 4-lane unsigned 8x8 inner product: two 32-bit words in,
// 18-bit sum of the four 16-bit lane products out.
module bitblade_dot4
    import bitblade_pkg::*;
(
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic [DOT_W-1:0] dot
);

    logic [15:0] prod;

    always_comb begin
        dot  = '0;
        prod = '0;
        for (int i = 0; i < 4; i++) begin
            prod = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
            dot  = dot + DOT_W'(prod);
        end
    end

endmodule

// File: rtl/bitblade_cfu_ctrl.sv
// CFU command/response controller around the 4-lane dot-product datapath.
// Optional build macro BITBLADE_ACC_SAT_EN: saturating MAC with a sticky flag.
module bitblade_cfu_ctrl
    import bitblade_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int OPND_W = LANES * 8;

    state_t              state;
    logic [OPND_W-1:0]   a_p0;
    logic [OPND_W-1:0]   b_p0;
    logic [2:0]          op_p0;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_nxt;
    logic [31:0]         rsp_nxt;
    logic [DOT_W-1:0]    dot;
    logic [ACC_W-1:0]    dot_ext;
    logic [ACC_W-1:0]    mac_acc;
    logic                unused_fid;
`ifdef BITBLADE_ACC_SAT_EN
    logic                sat_flag;
    logic                sat_nxt;
    logic                mac_ovf;
`endif

    function automatic logic [31:0] to_rsp(input logic [ACC_W-1:0] v);
        return 32'(v);
    endfunction

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] x,
                                                 input logic [ACC_W-1:0] y);
        logic [ACC_W-1:0] sum;
        sum = x + y;
`ifdef BITBLADE_ACC_SAT_EN
        return (sum < x) ? '1 : sum;
`else
        return sum;
`endif
    endfunction

    assign unused_fid = ^cmd_payload_function_id[9:3];
    assign cmd_ready  = (state == IDLE);

    // EXEC stage: datapath operates on the operands captured at accept
    bitblade_dot4 u_dot4 (
        .a   (a_p0),
        .b   (b_p0),
        .dot (dot)
    );

    assign dot_ext = ACC_W'(dot);
    assign mac_acc = acc_add(acc, dot_ext);
`ifdef BITBLADE_ACC_SAT_EN
    assign mac_ovf = (acc + dot_ext) < acc;
`endif

    always_comb begin
        acc_nxt = acc;
        rsp_nxt = '0;
`ifdef BITBLADE_ACC_SAT_EN
        sat_nxt = sat_flag;
`endif
        case (op_p0)
            OP_MAC: begin
                acc_nxt = mac_acc;
                rsp_nxt = to_rsp(mac_acc);
`ifdef BITBLADE_ACC_SAT_EN
                sat_nxt = sat_flag | mac_ovf;
`endif
            end
            OP_DOT: rsp_nxt = to_rsp(dot_ext);
            OP_CLR: begin
                rsp_nxt = to_rsp(acc);
                acc_nxt = '0;
`ifdef BITBLADE_ACC_SAT_EN
                sat_nxt = 1'b0;
`endif
            end
            OP_RD: rsp_nxt = to_rsp(acc);
            OP_LD: begin
                rsp_nxt = to_rsp(acc);
                acc_nxt = ACC_W'(a_p0);
`ifdef BITBLADE_ACC_SAT_EN
                sat_nxt = 1'b0;
`endif
            end
`ifdef BITBLADE_ACC_SAT_EN
            OP_SATRD: begin
                rsp_nxt = 32'(sat_flag);
                sat_nxt = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Control and registered outputs; unused opcodes fall through to a zero response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            a_p0                  <= '0;
            b_p0                  <= '0;
            op_p0                 <= '0;
            acc                   <= '0;
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
`ifdef BITBLADE_ACC_SAT_EN
            sat_flag              <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_p0  <= OPND_W'(cmd_payload_inputs_0);
                        b_p0  <= OPND_W'(cmd_payload_inputs_1);
                        op_p0 <= cmd_payload_function_id[2:0];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    acc                   <= acc_nxt;
                    rsp_payload_outputs_0 <= rsp_nxt;
                    rsp_valid             <= 1'b1;
`ifdef BITBLADE_ACC_SAT_EN
                    sat_flag              <= sat_nxt;
`endif
                    state                 <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
